// File: rtl/gate_id_pkg.sv
// Shared gate codes, truth-table constants, FSM encoding and truth-table decode
// for the gate identifier.
package gate_id_pkg;

    localparam logic [2:0] GATE_AND   = 3'b000;
    localparam logic [2:0] GATE_OR    = 3'b001;
    localparam logic [2:0] GATE_NOT_A = 3'b010;
    localparam logic [2:0] GATE_NAND  = 3'b011;
    localparam logic [2:0] GATE_NOR   = 3'b100;
    localparam logic [2:0] GATE_XOR   = 3'b101;
    localparam logic [2:0] GATE_XNOR  = 3'b110;
    localparam logic [2:0] GATE_ZERO  = 3'b111;

    // Bit i of each table is the gate output for {a,b} = i.
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_ZERO  = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Returns {known, gate_code}.
    function automatic logic [3:0] decode_gate(input logic [3:0] tt);
        logic [3:0] r;
        case (tt)
            TT_AND:   r = {1'b1, GATE_AND};
            TT_OR:    r = {1'b1, GATE_OR};
            TT_NOT_A: r = {1'b1, GATE_NOT_A};
            TT_NAND:  r = {1'b1, GATE_NAND};
            TT_NOR:   r = {1'b1, GATE_NOR};
            TT_XOR:   r = {1'b1, GATE_XOR};
            TT_XNOR:  r = {1'b1, GATE_XNOR};
            TT_ZERO:  r = {1'b1, GATE_ZERO};
            default:  r = {1'b0, GATE_ZERO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_identifier_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gate_identifier.sv
// Drives all four input vectors into an unknown 2-input gate, samples the
// synchronized response after a settle time and decodes the truth table.
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       resp,
    output logic       stim_a,
    output logic       stim_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic [2:0] gate_code,
    output logic       known
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       stim, stim_n;
    logic [3:0]       shadow, shadow_n;
    logic [3:0]       tt_n;
    logic [2:0]       code_n;
    logic             known_n;
    logic             resp_sync;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (resp),
        .q   (resp_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            stim        <= '0;
            shadow      <= '0;
            truth_table <= '0;
            gate_code   <= '0;
            known       <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            stim        <= stim_n;
            shadow      <= shadow_n;
            truth_table <= tt_n;
            gate_code   <= code_n;
            known       <= known_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        stim_n   = stim;
        shadow_n = shadow;
        tt_n     = truth_table;
        code_n   = gate_code;
        known_n  = known;
        case (state)
            ST_IDLE: begin
                stim_n = '0;
                if (start) begin
                    state_n = ST_DRIVE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            ST_DRIVE: begin
                state_n = ST_SETTLE;
                cnt_n   = '0;
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = ST_SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                shadow_n[idx] = resp_sync;
                if (idx == 2'd3) begin
                    // Results only move here, so they hold steady for a whole run.
                    state_n           = ST_DONE;
                    stim_n            = '0;
                    tt_n              = shadow_n;
                    {known_n, code_n} = decode_gate(shadow_n);
                end else begin
                    state_n = ST_DRIVE;
                    idx_n   = idx + 2'd1;
                    stim_n  = idx + 2'd1;
                    cnt_n   = '0;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign stim_a = stim[1];
    assign stim_b = stim[0];
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

endmodule
